// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues BRAM word reads, tracks the one in-flight read and holds results in a 2-entry queue.
// Optional build macro FETCH_PERF_EN adds stall and redirect event counters.
module fetch_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 9,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_branch,
  input  logic [AWIDTH-1:0] branch_loc,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] o_instr,
  output logic [AWIDTH-1:0] o_pc,
  output logic              o_valid,
  input  logic              i_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam logic [AWIDTH-1:0] RESET_ADDR = AWIDTH'(RESET_PC);
  localparam logic [AWIDTH-1:0] ADDR_ONE   = {{(AWIDTH-1){1'b0}}, 1'b1};

  logic [AWIDTH-1:0] pc_r;
  logic [AWIDTH-1:0] inflight_pc_r;
  logic              inflight_r;
  logic [DWIDTH-1:0] q_instr_r [2];
  logic [AWIDTH-1:0] q_pc_r [2];
  logic              head_r;
  logic              tail_r;
  logic [1:0]        occ_r;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [2:0]        demand_s;

  assign o_instr = q_instr_r[head_r];
  assign o_pc    = q_pc_r[head_r];

  // Per-cycle handshake, capture and issue decisions; a redirect hides the queue and overrides the address.
  always_comb begin
    o_valid  = 1'b0;
    pop_s    = 1'b0;
    push_s   = 1'b0;
    issue_s  = 1'b0;
    demand_s = 3'd0;
    mem_en   = 1'b0;
    mem_addr = pc_r;
    if (reset) begin
      mem_en = 1'b0;
    end else if (take_branch) begin
      issue_s  = 1'b1;
      mem_en   = 1'b1;
      mem_addr = branch_loc;
    end else begin
      o_valid  = (occ_r != 2'd0);
      pop_s    = o_valid & i_ready;
      push_s   = inflight_r;
      // Entries that will be held after this cycle; only issue if one slot remains for the new read.
      demand_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      issue_s  = (demand_s < 3'd2);
      mem_en   = issue_s;
    end
  end

  // Queue storage, pointers, occupancy, PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_ADDR;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_ADDR;
      head_r        <= 1'b0;
      tail_r        <= 1'b0;
      occ_r         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr_r[i] <= '0;
        q_pc_r[i]    <= '0;
      end
    end else if (take_branch) begin
      pc_r          <= branch_loc + ADDR_ONE;
      inflight_r    <= 1'b1;
      inflight_pc_r <= branch_loc;
      head_r        <= 1'b0;
      tail_r        <= 1'b0;
      occ_r         <= 2'd0;
    end else begin
      if (push_s) begin
        q_instr_r[tail_r] <= mem_rdata;
        q_pc_r[tail_r]    <= inflight_pc_r;
        tail_r            <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
      if (issue_s) begin
        pc_r          <= pc_r + ADDR_ONE;
        inflight_pc_r <= pc_r;
        inflight_r    <= 1'b1;
      end else begin
        inflight_r    <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] redirect_cnt_r;

  // Free-running wrapping event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r    <= 32'd0;
      redirect_cnt_r <= 32'd0;
    end else begin
      if (o_valid & ~i_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (take_branch) begin
        redirect_cnt_r <= redirect_cnt_r + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_r;
  assign perf_redirects    = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random back-pressure, redirects and resets,
// checked against a stream-level model (start point, latency, next expected PC).
module tb_fetch_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NWORDS = 512;

  logic          clk;
  logic          reset;
  logic          take_branch;
  logic [AW-1:0] branch_loc;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_pc;
  logic          o_valid;
  logic          i_ready;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_redirects;
  int            stall_m;
  int            red_m;
`endif

  logic [DW-1:0] mem [NWORDS];

  int n_vec;
  int n_err;
  int cyc;
  int valid_from;
  int next_pc;
  bit after_reset;

  fetch_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .RESET_PC(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .take_branch      (take_branch),
    .branch_loc       (branch_loc),
    .mem_addr         (mem_addr),
    .mem_en           (mem_en),
    .mem_rdata        (mem_rdata),
    .o_instr          (o_instr),
    .o_pc             (o_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects   (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the stream model, advance the model.
  task automatic step(input logic rst, input logic br, input logic [AW-1:0] loc, input logic rdy);
    bit exp_valid;
    bit exp_en;
    int ahead;
    @(posedge clk);
    #2;
    reset       = rst;
    take_branch = br;
    branch_loc  = loc;
    i_ready     = rdy;
    #2;
    if (rst) begin
      check("mem_en_in_reset", 32'(mem_en), 32'(0));
    end else begin
`ifdef FETCH_PERF_EN
      check("perf_stall", perf_stall_cycles, 32'(stall_m));
      check("perf_redir", perf_redirects, 32'(red_m));
`endif
      if (br) begin
        check("valid_on_redirect", 32'(o_valid), 32'(0));
        check("en_on_redirect", 32'(mem_en), 32'(1));
        check("addr_on_redirect", 32'(mem_addr), 32'(loc));
      end else begin
        exp_valid = (cyc >= valid_from);
        check("valid", 32'(o_valid), 32'(exp_valid));
        if (exp_valid) begin
          check("pc", 32'(o_pc), 32'(next_pc));
          check("instr", o_instr, 32'h1000 + 32'(next_pc));
        end else if (after_reset) begin
          check("pc_after_reset", 32'(o_pc), 32'(0));
          check("instr_after_reset", o_instr, 32'(0));
        end
        exp_en = exp_valid ? rdy : 1'b1;
        check("mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) begin
          ahead = exp_valid ? 2 : 2 - (valid_from - cyc);
          check("mem_addr", 32'(mem_addr), 32'((next_pc + ahead) % NWORDS));
        end
        if (exp_valid && rdy) next_pc = (next_pc + 1) % NWORDS;
`ifdef FETCH_PERF_EN
        if (exp_valid && !rdy) stall_m++;
`endif
      end
    end
    if (rst) begin
      valid_from  = cyc + 3;
      next_pc     = 0;
      after_reset = 1'b1;
`ifdef FETCH_PERF_EN
      stall_m = 0;
      red_m   = 0;
`endif
    end else if (br) begin
      valid_from  = cyc + 2;
      next_pc     = int'(loc);
      after_reset = 1'b0;
`ifdef FETCH_PERF_EN
      red_m++;
`endif
    end
    cyc++;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; valid_from = 0; next_pc = 0; after_reset = 1'b0;
`ifdef FETCH_PERF_EN
    stall_m = 0; red_m = 0;
`endif
    for (int k = 0; k < NWORDS; k++) mem[k] = 32'h1000 + 32'(k);
    reset = 1'b1; take_branch = 1'b0; branch_loc = '0; i_ready = 1'b0;

    // Reset, then streaming with i_ready held high.
    step(1'b1, 1'b0, 9'h000, 1'b1);
    step(1'b1, 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    // Back-pressure for six cycles, then release.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'h000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    // Fill the queue, then redirect while it is full.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b1, 9'h040, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    // Wrap across the top of the address space.
    step(1'b0, 1'b1, 9'h1FE, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    // Back-to-back redirects: the last one wins.
    step(1'b0, 1'b1, 9'h0A0, 1'b1);
    step(1'b0, 1'b1, 9'h120, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    // Single-cycle reset mid-stream with a full queue; redirect in the same cycle is overridden.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b1, 1'b1, 9'h055, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'h000, 1'b1);

`ifdef FETCH_PERF_EN
    // Counter scenario: 4 stall cycles and 2 redirects after a reset.
    step(1'b1, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    check("perf_stall_reset", perf_stall_cycles, 32'd0);
    check("perf_redir_reset", perf_redirects, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b1, 9'h010, 1'b1);
    step(1'b0, 1'b1, 9'h020, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    check("perf_stall_4", perf_stall_cycles, 32'd4);
    check("perf_redir_2", perf_redirects, 32'd2);
`endif

    // Random phase: back-pressure, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 1) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 6) ? 1'b1 : 1'b0,
           AW'($urandom_range(NWORDS - 1)),
           ($urandom_range(99) < 70) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
